// File: rtl/mux_3in1out_reg.sv
// Three-input operand mux for the datapath: a combinational output for same-cycle use,
// a registered copy for pipelined consumers, and illegal-select (SEL=3) flags.
module mux_3in1out_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic [1:0]       SEL,
    input  logic             EN,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_Q,
    output logic             SEL_ERR,
    output logic             ERR_STICKY
);

    logic [WIDTH-1:0] w_mux;
    logic             w_sel_illegal;
    logic [WIDTH-1:0] r_out_q;
    logic             r_sel_err;
    logic             r_err_sticky;

    // Default branch also covers X/Z on SEL, so nothing can latch.
    always_comb begin
        w_mux = DEFAULT_VAL;
        case (SEL)
            2'd0:    w_mux = IN0;
            2'd1:    w_mux = IN1;
            2'd2:    w_mux = IN2;
            default: w_mux = DEFAULT_VAL;
        endcase
    end

    assign w_sel_illegal = (SEL == 2'd3);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_out_q      <= '0;
            r_sel_err    <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            if (EN) begin
                r_out_q   <= w_mux;
                r_sel_err <= w_sel_illegal;
            end
            // A new illegal load outranks a clear on the same edge.
            if (EN && w_sel_illegal) begin
                r_err_sticky <= 1'b1;
            end else if (CLR_ERR) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    assign OUT        = w_mux;
    assign OUT_Q      = r_out_q;
    assign SEL_ERR    = r_sel_err;
    assign ERR_STICKY = r_err_sticky;

endmodule

// File: tb/tb_mux_3in1out_reg.sv
// Directed bench for mux_3in1out_reg: combinational select, registered load/hold,
// sticky error set/clear priority and asynchronous reset.
module tb_mux_3in1out_reg;

    logic       CLK;
    logic       RST;
    logic [7:0] IN0, IN1, IN2;
    logic [1:0] SEL;
    logic       EN;
    logic       CLR_ERR;
    logic [7:0] OUT;
    logic [7:0] OUT_Q;
    logic       SEL_ERR;
    logic       ERR_STICKY;

    int checks   = 0;
    int failures = 0;

    mux_3in1out_reg #(.WIDTH(8), .DEFAULT_VAL(8'h00)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN0        (IN0),
        .IN1        (IN1),
        .IN2        (IN2),
        .SEL        (SEL),
        .EN         (EN),
        .CLR_ERR    (CLR_ERR),
        .OUT        (OUT),
        .OUT_Q      (OUT_Q),
        .SEL_ERR    (SEL_ERR),
        .ERR_STICKY (ERR_STICKY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #2;
        checks++;
        if (OUT_Q !== 8'h00) begin
            failures++;
            $display("FAIL reset_out_q actual=%h required=00", OUT_Q);
        end
        checks++;
        if ({SEL_ERR, ERR_STICKY} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags actual=%b required=00", {SEL_ERR, ERR_STICKY});
        end
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_comb_sweep();
        logic [7:0] exp_out [4];
        exp_out = '{8'h11, 8'h22, 8'h33, 8'h00};
        EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            SEL = 2'(i);
            #1;
            checks++;
            if (OUT !== exp_out[i]) begin
                failures++;
                $display("FAIL comb_sel%0d actual=%h required=%h", i, OUT, exp_out[i]);
            end
            #99;
        end
        checks++;
        if (OUT_Q !== 8'h00) begin
            failures++;
            $display("FAIL comb_out_q_hold actual=%h required=00", OUT_Q);
        end
    endtask

    task automatic test_load();
        SEL = 2'd1;
        EN  = 1'b1;
        #1;
        checks++;
        if (OUT_Q !== 8'h00) begin
            failures++;
            $display("FAIL load_before_edge actual=%h required=00", OUT_Q);
        end
        tick();
        checks++;
        if (OUT_Q !== 8'h22) begin
            failures++;
            $display("FAIL load_out_q actual=%h required=22", OUT_Q);
        end
        checks++;
        if (SEL_ERR !== 1'b0) begin
            failures++;
            $display("FAIL load_sel_err actual=%b required=0", SEL_ERR);
        end
    endtask

    task automatic test_illegal_sel();
        SEL = 2'd3;
        EN  = 1'b1;
        tick();
        checks++;
        if ({OUT_Q, SEL_ERR, ERR_STICKY} !== {8'h00, 2'b11}) begin
            failures++;
            $display("FAIL illegal_load actual=%h/%b/%b required=00/1/1", OUT_Q, SEL_ERR, ERR_STICKY);
        end
        SEL = 2'd0;
        tick();
        checks++;
        if ({OUT_Q, SEL_ERR, ERR_STICKY} !== {8'h11, 2'b01}) begin
            failures++;
            $display("FAIL illegal_recover actual=%h/%b/%b required=11/0/1", OUT_Q, SEL_ERR, ERR_STICKY);
        end
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
        checks++;
        if (ERR_STICKY !== 1'b0) begin
            failures++;
            $display("FAIL sticky_clear actual=%b required=0", ERR_STICKY);
        end
    endtask

    task automatic test_hold();
        SEL = 2'd2;
        EN  = 1'b1;
        tick();
        checks++;
        if (OUT_Q !== 8'h33) begin
            failures++;
            $display("FAIL hold_load actual=%h required=33", OUT_Q);
        end
        EN  = 1'b0;
        IN2 = 8'h5A;
        #1;
        checks++;
        if (OUT !== 8'h5A) begin
            failures++;
            $display("FAIL hold_comb actual=%h required=5a", OUT);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (OUT_Q !== 8'h33) begin
                failures++;
                $display("FAIL hold_edge%0d actual=%h required=33", i, OUT_Q);
            end
        end
        IN2 = 8'h33;
    endtask

    task automatic test_async_reset();
        EN  = 1'b1;
        SEL = 2'd3;
        tick();
        SEL = 2'd1;
        tick();
        checks++;
        if ({OUT_Q, ERR_STICKY} !== {8'h22, 1'b1}) begin
            failures++;
            $display("FAIL areset_setup actual=%h/%b required=22/1", OUT_Q, ERR_STICKY);
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({OUT_Q, SEL_ERR, ERR_STICKY} !== {8'h00, 2'b00}) begin
            failures++;
            $display("FAIL areset_immediate actual=%h/%b/%b required=00/0/0", OUT_Q, SEL_ERR, ERR_STICKY);
        end
        checks++;
        if (OUT !== 8'h22) begin
            failures++;
            $display("FAIL areset_comb actual=%h required=22", OUT);
        end
        tick();
        checks++;
        if (OUT_Q !== 8'h00) begin
            failures++;
            $display("FAIL areset_hold actual=%h required=00", OUT_Q);
        end
        RST = 1'b0;
        SEL = 2'd2;
        tick();
        checks++;
        if (OUT_Q !== 8'h33) begin
            failures++;
            $display("FAIL areset_first_load actual=%h required=33", OUT_Q);
        end
    endtask

    task automatic test_set_wins();
        EN      = 1'b1;
        SEL     = 2'd3;
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
        checks++;
        if ({SEL_ERR, ERR_STICKY} !== 2'b11) begin
            failures++;
            $display("FAIL set_wins actual=%b required=11", {SEL_ERR, ERR_STICKY});
        end
        EN      = 1'b0;
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
        checks++;
        if (ERR_STICKY !== 1'b0) begin
            failures++;
            $display("FAIL clear_with_en0 actual=%b required=0", ERR_STICKY);
        end
    endtask

    initial begin
        RST     = 1'b0;
        IN0     = 8'h11;
        IN1     = 8'h22;
        IN2     = 8'h33;
        SEL     = 2'd0;
        EN      = 1'b0;
        CLR_ERR = 1'b0;
        test_reset();
        test_comb_sweep();
        test_load();
        test_illegal_sel();
        test_hold();
        test_async_reset();
        test_set_wins();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
